imem_boot_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the `processor`: it receives a byte stream, assembles 32-bit instruction words, and writes them sequentially into instruction memory starting at word address 0. It holds the processor in reset (`cpu_reset`) until the whole image is written, then releases it. It replaces the current arrangement, in which the processor starts from a pre-initialised instruction memory one cycle after reset.

---
 rtl/imem_boot_loader.sv | 145 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a header-prefixed byte stream, packs it into 32-bit words and
// writes them to instruction memory from address 0, holding the processor in reset until done.
`default_nettype none

module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  ref_clk,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [31:0] C_CAPACITY = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [15:0]         r_num_words;
  logic [ADDR_WIDTH:0] r_word_cnt;
  logic [1:0]          r_byte_idx;
  logic [31:0]         r_word;

  logic                w_ready;
  logic                w_accept;
  logic [15:0]         w_hdr_count;
  logic                w_last_word;
  logic [31:0]         w_assembled;

  assign w_ready     = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_DATA);
  assign w_accept    = byte_valid && w_ready;
  assign w_hdr_count = {r_num_words[15:8], byte_data};
  assign w_last_word = ((32'(r_word_cnt) + 32'd1) == 32'(r_num_words));

  // Byte lane order only affects packing; the header is always big-endian.
  generate
    if (BIG_ENDIAN) begin : g_big_endian
      assign w_assembled = {r_word[23:0], byte_data};
    end else begin : g_little_endian
      assign w_assembled = {byte_data, r_word[31:8]};
    end
  endgenerate

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    imem_we      = 1'b0;
    cpu_reset    = 1'b1;
    load_done    = 1'b0;
    load_error   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (w_accept) begin
          w_next_state = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (w_accept) begin
          if (w_hdr_count == 16'd0) begin
            w_next_state = S_DONE;
          end else if (32'(w_hdr_count) > C_CAPACITY) begin
            w_next_state = S_ERROR;
          end else begin
            w_next_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept && (r_byte_idx == 2'd3)) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        imem_we      = 1'b1;
        w_next_state = w_last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        cpu_reset = 1'b0;
        load_done = 1'b1;
      end
      S_ERROR: begin
        load_error = 1'b1;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      r_num_words <= 16'd0;
      r_word_cnt  <= '0;
      r_byte_idx  <= 2'd0;
      r_word      <= 32'd0;
    end else begin
      case (r_state)
        S_HDR_HI: if (w_accept) r_num_words[15:8] <= byte_data;
        S_HDR_LO: if (w_accept) r_num_words[7:0]  <= byte_data;
        S_DATA: begin
          if (w_accept) begin
            r_word     <= w_assembled;
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: r_word_cnt <= r_word_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign byte_ready = w_ready;
  assign imem_addr  = r_word_cnt[ADDR_WIDTH-1:0];
  assign imem_wdata = r_word;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: header-table vectors plus scoreboarded image loads.
`default_nettype none

module tb_imem_boot_loader;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       ready;
    logic       done;
    logic       err;
    logic       cpurst;
  } hdr_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       ref_clk = 1'b0;
  logic       reset   = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data  = 8'h00;
  logic       sel_le     = 1'b0;

  logic       ready_be, we_be, cpurst_be, done_be, err_be;
  logic [7:0] addr_be;
  logic [31:0] wdata_be;
  logic       ready_le, we_le, cpurst_le, done_le, err_le;
  logic [7:0] addr_le;
  logic [31:0] wdata_le;

  logic        rdy, we, cpurst, done, err;
  logic [7:0]  addr;
  logic [31:0] wdata;

  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  wr_t  sb[$];
  logic [7:0] stm[$];
  hdr_vec_t vecs[5];

  always #5 ref_clk = ~ref_clk;

  imem_boot_loader #(.ADDR_WIDTH(8), .BIG_ENDIAN(1'b1)) dut_be (
    .ref_clk(ref_clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready_be), .imem_we(we_be), .imem_addr(addr_be), .imem_wdata(wdata_be),
    .cpu_reset(cpurst_be), .load_done(done_be), .load_error(err_be)
  );

  imem_boot_loader #(.ADDR_WIDTH(8), .BIG_ENDIAN(1'b0)) dut_le (
    .ref_clk(ref_clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready_le), .imem_we(we_le), .imem_addr(addr_le), .imem_wdata(wdata_le),
    .cpu_reset(cpurst_le), .load_done(done_le), .load_error(err_le)
  );

  assign rdy    = sel_le ? ready_le  : ready_be;
  assign we     = sel_le ? we_le     : we_be;
  assign addr   = sel_le ? addr_le   : addr_be;
  assign wdata  = sel_le ? wdata_le  : wdata_be;
  assign cpurst = sel_le ? cpurst_le : cpurst_be;
  assign done   = sel_le ? done_le   : done_be;
  assign err    = sel_le ? err_le    : err_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every clock advance goes through here so no write strobe goes unobserved.
  task automatic tick();
    wr_t e;
    @(posedge ref_clk);
    #1;
    if (we === 1'b1) begin
      we_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h expected none", addr, wdata);
      end else begin
        e = sb.pop_front();
        chk("write_addr", 32'(addr), e.addr);
        chk("write_data", wdata, e.data);
      end
      chk("ready_in_write", 32'(rdy), 32'd0);
      chk("cpu_reset_in_write", 32'(cpurst), 32'd1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!rdy && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    tick();
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    sb.delete();
    we_cnt = 0;
  endtask

  task automatic run_stream(input bit toggle, input int gap_at, input int start);
    wr_t e;
    for (int i = start; i < stm.size(); i++) begin
      if (i >= 2 && ((i - 2) % 4) == 3) begin
        e.addr = 32'((i - 2) / 4);
        if (sel_le) e.data = {stm[i], stm[i-1], stm[i-2], stm[i-3]};
        else        e.data = {stm[i-3], stm[i-2], stm[i-1], stm[i]};
        sb.push_back(e);
      end
      send_byte(stm[i]);
      if (toggle && i < stm.size() - 1) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        tick();
      end
      if (i == gap_at) begin
        byte_valid = 1'b0;
        repeat (10) tick();
      end
    end
    byte_valid = 1'b0;
  endtask

  // Called with the bench sampling the final WRITE cycle; release must follow one cycle later.
  task automatic finish_load(input int exp_writes, input string tag);
    tick();
    chk({tag, "_load_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_reset"}, 32'(cpurst), 32'd0);
    chk({tag, "_ready_done"}, 32'(rdy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_we_count"}, 32'(we_cnt), 32'(exp_writes));
  endtask

  task automatic set_two_word();
    stm = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{hi: 8'h00, lo: 8'h00, ready: 1'b0, done: 1'b1, err: 1'b0, cpurst: 1'b0};
    vecs[1] = '{hi: 8'h01, lo: 8'h01, ready: 1'b0, done: 1'b0, err: 1'b1, cpurst: 1'b1};
    vecs[2] = '{hi: 8'h01, lo: 8'h00, ready: 1'b1, done: 1'b0, err: 1'b0, cpurst: 1'b1};
    vecs[3] = '{hi: 8'h00, lo: 8'h01, ready: 1'b1, done: 1'b0, err: 1'b0, cpurst: 1'b1};
    vecs[4] = '{hi: 8'hFF, lo: 8'hFF, ready: 1'b0, done: 1'b0, err: 1'b1, cpurst: 1'b1};

    // Reset held with valid high: nothing moves.
    reset = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (3) begin
      tick();
      chk("rst_ready", 32'(rdy), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_cpu_reset", 32'(cpurst), 32'd1);
      chk("rst_done_err", {30'd0, done, err}, 32'd0);
    end
    reset = 1'b1;
    chk("ready_before_edge", 32'(rdy), 32'd0);
    tick();
    byte_valid = 1'b0;
    chk("ready_after_release", 32'(rdy), 32'd1);

    // Two-word big-endian load, back-to-back.
    do_reset();
    set_two_word();
    run_stream(1'b0, -1, 0);
    finish_load(2, "be2");

    // Same stream, valid toggling plus a 10-cycle gap inside the first word.
    do_reset();
    set_two_word();
    run_stream(1'b1, 3, 0);
    finish_load(2, "gap");

    // Header-only vectors.
    foreach (vecs[k]) begin
      do_reset();
      send_byte(vecs[k].hi);
      send_byte(vecs[k].lo);
      byte_valid = 1'b0;
      chk("hdr_ready", 32'(rdy), 32'(vecs[k].ready));
      chk("hdr_done", 32'(done), 32'(vecs[k].done));
      chk("hdr_error", 32'(err), 32'(vecs[k].err));
      chk("hdr_cpu_reset", 32'(cpurst), 32'(vecs[k].cpurst));
      byte_valid = 1'b1;
      byte_data  = 8'h5A;
      repeat (3) tick();
      byte_valid = 1'b0;
      chk("hdr_hold_done", 32'(done), 32'(vecs[k].done));
      chk("hdr_hold_error", 32'(err), 32'(vecs[k].err));
      chk("hdr_hold_cpu_reset", 32'(cpurst), 32'(vecs[k].cpurst));
      chk("hdr_we_count", 32'(we_cnt), 32'd0);
    end

    // Full-capacity image: N = 256, last write at address 255.
    do_reset();
    stm.delete();
    stm.push_back(8'h01);
    stm.push_back(8'h00);
    for (int i = 0; i < 1024; i++) stm.push_back(8'($urandom));
    run_stream(1'b0, -1, 0);
    finish_load(256, "full");

    // Little-endian packing on the second instance.
    sel_le = 1'b1;
    do_reset();
    stm = '{8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    run_stream(1'b0, -1, 0);
    finish_load(1, "le");
    sel_le = 1'b0;

    // Reset in the middle of the first word, then a full reload.
    do_reset();
    set_two_word();
    for (int i = 0; i < 4; i++) send_byte(stm[i]);
    byte_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(rdy), 32'd0);
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_addr", 32'(addr), 32'd0);
    chk("mid_rst_wdata", wdata, 32'd0);
    chk("mid_rst_cpu_reset", 32'(cpurst), 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    sb.delete();
    we_cnt = 0;
    run_stream(1'b0, -1, 0);
    finish_load(2, "reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
